uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
UART RX stage on the far end of the TX line. It deserialises frames (start, 8 data bits LSB first, parity slot, stop) from the serial input and writes each good byte into the downstream receive FIFO through a write strobe. It flags framing, parity and overrun errors with one-cycle pulses. Frame format and bit timing match the transmitter: same clock_freq/baud parameters, same bit period.

Parameters:
clock_freq, 50_000_000, system clock frequency in Hz
baud, 9600, line rate in bits/s; cycles_per_bit = clock_freq / baud (integer divide), half_bit = cycles_per_bit / 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
receive_wire  input  1  UART RX line, idle high, asynchronous to clk
fifo_full  input  1  downstream FIFO cannot accept a write this cycle
data_out  output  8  received byte, valid while fifo_write=1
fifo_write  output  1  one-cycle write strobe to downstream FIFO
parity_error  output  1  one-cycle pulse, parity mismatch (see Optional Feature)
framing_error  output  1  one-cycle pulse, stop bit sampled low
overrun_error  output  1  one-cycle pulse, good byte dropped because fifo_full=1
state_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset wins over all other activity, including mid-frame.
- Reset values: data_out=0, fifo_write=0, all error outputs 0, state_busy=0, FSM=IDLE, counters=0, both synchroniser flops=1.
- receive_wire passes through a 2-FF synchroniser. All logic uses the synchronised value rx_s, which adds 2 cycles of latency.
- Bit counter is 32 bits. It clears on every state change and on every bit sample.
- IDLE: rx_s=0 -> START, counter=0.
- START: sample at counter==half_bit-1. If rx_s=0 -> DATA with bit_index=0. If rx_s=1 -> false start, back to IDLE with no pulse.
- DATA: sample at counter==cycles_per_bit-1. Shift the bit into a shift register LSB first. After bit_index 7 -> PARITY. bit_index is 3 bits and never wraps inside a frame.
- PARITY: sample at counter==cycles_per_bit-1 and store it. Even parity: XOR of data bits and parity bit must equal 0. Then -> STOP.
- STOP: sample at counter==cycles_per_bit-1.
  - rx_s=1, no parity error, fifo_full=0 -> next cycle fifo_write=1, data_out=byte, FSM -> IDLE.
  - rx_s=1, fifo_full=1 -> overrun_error pulse, byte dropped, -> IDLE.
  - rx_s=0 -> framing_error pulse, byte dropped, -> RECOVER.
- Returning to IDLE at mid-stop gives half a bit of margin for back-to-back frames.
- RECOVER: wait until rx_s=1, then -> IDLE. This prevents a break condition from being decoded as a stream of 0x00 frames. state_busy stays high.
- Priority when several faults hit one frame: framing_error > parity_error > overrun_error. Only one error pulse is raised per frame.
- Latency: fifo_write rises 1 cycle after the stop-bit sample, i.e. about 2 + half_bit + 10*cycles_per_bit cycles after the start-bit falling edge on receive_wire.
- fifo_full is evaluated only in the stop-sample cycle.

Optional Feature:
Macro UART_RX_PARITY_CHECK_EN.
- Defined: a parity mismatch raises parity_error for one cycle and drops the byte (no fifo_write).
- Not defined: the parity slot is still timed and sampled but ignored. parity_error is tied to 0 and the byte is written if the stop bit is good.

Test Plan:
(Test parameters: clock_freq=1_000_000, baud=100_000, so cycles_per_bit=10, half_bit=5.)
1. Frame 0xA5, parity 0, stop 1 -> exactly one fifo_write with data_out=0xA5; no error pulses; state_busy low afterwards.
2. Back-to-back frames 0x00 (parity 0) then 0xFF (parity 0), no idle gap -> two writes in order, 0x00 then 0xFF.
3. Low glitch of 3 cycles on an idle line -> no fifo_write, no errors; state_busy returns low within 8 cycles.
4. Frame 0x3C with stop bit 0, line held low 30 more cycles, then high -> one framing_error pulse; no write; state_busy stays high until the line returns high; a following 0x12 frame is received correctly.
5. Frame 0x01 with parity 0 (wrong) -> with macro defined: parity_error pulse and no write. Without the macro: write of 0x01 and no error.
6. Frame 0x55 with fifo_full=1 at stop sample -> overrun_error pulse, no write. Separately, assert rst during DATA of frame 0x77 -> all outputs 0 next cycle, FSM in IDLE, and the next clean frame 0x77 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver
//   Receives UART frames (start, 8 data bits LSB first, parity slot, stop) from
//   an asynchronous serial line. Each good byte is written to a downstream FIFO
//   with a one-cycle strobe. Framing, parity and overrun faults are reported as
//   one-cycle pulses. At most one error pulse is raised per frame, with priority
//   framing > parity > overrun.
//
//   Parameters:
//     clock_freq    system clock frequency in Hz
//     baud          line rate in bits/s (cycles_per_bit = clock_freq / baud)
//
//   Ports:
//     clk            system clock, rising edge
//     rst            synchronous active-high reset
//     receive_wire   UART RX line, idle high, asynchronous to clk
//     fifo_full      downstream FIFO cannot accept a write this cycle
//     data_out       received byte, valid while fifo_write=1
//     fifo_write     one-cycle write strobe to the downstream FIFO
//     parity_error   one-cycle pulse on an even-parity mismatch
//     framing_error  one-cycle pulse when the stop bit is sampled low
//     overrun_error  one-cycle pulse when a good byte is dropped on fifo_full
//     state_busy     high whenever the FSM is not idle
//
//   Build option:
//     UART_RX_PARITY_CHECK_EN  when defined, a parity mismatch raises
//                              parity_error and drops the byte. When undefined,
//                              the parity slot is timed and sampled but ignored,
//                              and parity_error is tied low.
module uart_receiver #(
    parameter int clock_freq = 50_000_000,
    parameter int baud       = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       receive_wire,
    input  logic       fifo_full,
    output logic [7:0] data_out,
    output logic       fifo_write,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       state_busy
);

    localparam int          CYCLES_PER_BIT = clock_freq / baud;
    localparam int          HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam logic [31:0] BIT_LAST       = 32'(CYCLES_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST      = 32'(HALF_BIT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;

    logic        rx_sync_p0;
    logic        rx_s;
    logic [2:0]  state;
    logic [31:0] bit_cnt;
    logic [2:0]  bit_index;
    logic [7:0]  shift_reg;

`ifdef UART_RX_PARITY_CHECK_EN
    logic        parity_bit;

    // Even parity: data bits together with the parity bit must XOR to zero.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`else
    assign parity_error = 1'b0;
`endif

    assign state_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0    <= 1'b1;
            rx_s          <= 1'b1;
            state         <= ST_IDLE;
            bit_cnt       <= 32'd0;
            bit_index     <= 3'd0;
            shift_reg     <= 8'd0;
            data_out      <= 8'd0;
            fifo_write    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_bit    <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            // Stage boundary: two-flop synchroniser for the asynchronous line.
            rx_sync_p0    <= receive_wire;
            rx_s          <= rx_sync_p0;

            // Pulses last exactly one cycle unless re-asserted below.
            fifo_write    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_error  <= 1'b0;
`endif

            case (state)
                ST_IDLE: begin
                    bit_cnt <= 32'd0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end

                // Mid-start recheck rejects short low glitches.
                ST_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= 32'd0;
                        if (!rx_s) begin
                            state     <= ST_DATA;
                            bit_index <= 3'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end

                ST_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= 32'd0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_index == 3'd7) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end

                // The parity slot is always timed so frame alignment is kept.
                ST_PARITY: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= 32'd0;
`ifdef UART_RX_PARITY_CHECK_EN
                        parity_bit <= rx_s;
`endif
                        state <= ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end

                // Leaving at mid-stop leaves half a bit of margin for the
                // next start edge of a back-to-back frame.
                ST_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= 32'd0;
                        if (!rx_s) begin
                            framing_error <= 1'b1;
                            state         <= ST_RECOVER;
                        end
`ifdef UART_RX_PARITY_CHECK_EN
                        else if (parity_bad(shift_reg, parity_bit)) begin
                            parity_error <= 1'b1;
                            state        <= ST_IDLE;
                        end
`endif
                        else if (fifo_full) begin
                            overrun_error <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            fifo_write <= 1'b1;
                            data_out   <= shift_reg;
                            state      <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end

                // A held-low line (break) is waited out instead of being
                // decoded as a stream of 0x00 frames.
                ST_RECOVER: begin
                    bit_cnt <= 32'd0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    bit_cnt <= 32'd0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Self-checking bench for uart_receiver at clock_freq=1_000_000,
//   baud=100_000 (10 clocks per bit). Expected bytes are queued as frames are
//   driven and popped by a monitor whenever fifo_write fires; error pulses are
//   counted by the monitor and compared against expected totals.
module tb_uart_receiver;

    localparam int CPB = 10;

    logic       clk;
    logic       rst;
    logic       receive_wire;
    logic       fifo_full;
    logic [7:0] data_out;
    logic       fifo_write;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       state_busy;

    int checks = 0;
    int errors = 0;

    int n_write = 0;
    int n_fe    = 0;
    int n_pe    = 0;
    int n_oe    = 0;
    int exp_write = 0;
    int exp_pe    = 0;

    logic [7:0] exp_q[$];

    uart_receiver #(
        .clock_freq(1_000_000),
        .baud      (100_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .receive_wire (receive_wire),
        .fifo_full    (fifo_full),
        .data_out     (data_out),
        .fifo_write   (fifo_write),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .state_busy   (state_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs change on posedge; the monitor samples on negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_write) begin
                n_write++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'd0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    check("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                end
            end
            if (framing_error) n_fe++;
            if (parity_error)  n_pe++;
            if (overrun_error) n_oe++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        receive_wire = v;
        repeat (CPB) @(negedge clk);
    endtask

    // The line is left at the stop value when the task returns.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"},      {24'd0, data_out}, 32'd0);
        check({tag, "_fifo_write"},    {31'd0, fifo_write}, 32'd0);
        check({tag, "_parity_error"},  {31'd0, parity_error}, 32'd0);
        check({tag, "_framing_error"}, {31'd0, framing_error}, 32'd0);
        check({tag, "_overrun_error"}, {31'd0, overrun_error}, 32'd0);
        check({tag, "_state_busy"},    {31'd0, state_busy}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        receive_wire = 1'b1;
        fifo_full    = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(5);

        // 1: single good frame
        exp_q.push_back(8'hA5);
        exp_write++;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(15);
        check("t1_writes", n_write, exp_write);
        check("t1_errors", n_fe + n_pe + n_oe, 0);
        check("t1_busy", {31'd0, state_busy}, 32'd0);

        // 2: back-to-back frames with no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_write += 2;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(15);
        check("t2_writes", n_write, exp_write);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: short low glitch must be rejected as a false start
        receive_wire = 1'b0;
        idle(3);
        receive_wire = 1'b1;
        idle(8);
        check("t3_busy", {31'd0, state_busy}, 32'd0);
        idle(10);
        check("t3_writes", n_write, exp_write);
        check("t3_errors", n_fe + n_pe + n_oe, 0);

        // 4: bad stop bit, line held low, then recovery and a clean frame
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(30);
        check("t4_busy_held", {31'd0, state_busy}, 32'd1);
        check("t4_framing", n_fe, 1);
        check("t4_writes", n_write, exp_write);
        receive_wire = 1'b1;
        idle(6);
        check("t4_busy_released", {31'd0, state_busy}, 32'd0);
        exp_q.push_back(8'h12);
        exp_write++;
        send_frame(8'h12, 1'b0, 1'b1);
        idle(15);
        check("t4_writes_after", n_write, exp_write);
        check("t4_framing_after", n_fe, 1);

        // 5: wrong parity on 0x01
`ifdef UART_RX_PARITY_CHECK_EN
        exp_pe++;
`else
        exp_q.push_back(8'h01);
        exp_write++;
`endif
        send_frame(8'h01, 1'b0, 1'b1);
        idle(15);
        check("t5_writes", n_write, exp_write);
        check("t5_parity", n_pe, exp_pe);
        check("t5_framing", n_fe, 1);

        // 6a: FIFO full at stop sample drops the byte
        fifo_full = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(15);
        fifo_full = 1'b0;
        check("t6_overrun", n_oe, 1);
        check("t6_writes", n_write, exp_write);

        // 6b: reset in the middle of the data bits of 0x77
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t6_busy_mid_frame", {31'd0, state_busy}, 32'd1);
        receive_wire = 1'b1;
        rst = 1'b1;
        idle(1);
        check_outputs_zero("midframe_reset");
        rst = 1'b0;
        idle(5);
        exp_q.push_back(8'h77);
        exp_write++;
        send_frame(8'h77, 1'b0, 1'b1);
        idle(15);
        check("t6_writes_after_reset", n_write, exp_write);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_framing", n_fe, 1);
        check("final_parity", n_pe, exp_pe);
        check("final_overrun", n_oe, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
